bcd_stopwatch: RTL

Parametrised stopwatch core: a tick prescaler, a start/stop/clear state machine, a saturating elapsed-time counter with a lap freeze, and an iterative binary-to-BCD converter feeding per-digit BCD to the seven-segment decoders. It replaces the fixed 1 ms / 6-digit counter path between the board clock and the display decoders, and adds pause/resume, lap capture and overflow handling.

---
 rtl/bcd_stopwatch.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/bcd_stopwatch.sv
// Stopwatch core: tick prescaler, start/stop/clear FSM, saturating elapsed counter
// with lap freeze, and a free-running double-dabble converter driving per-digit BCD.
module bcd_stopwatch #(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned DIGITS    = 6,
    parameter int unsigned MAX_COUNT = 999999
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                lap,
    input  logic                clear,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                bcd_valid,
    output logic                running,
    output logic                lap_active,
    output logic                overflow
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned SW = $clog2(CNT_W + 1);

    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_COUNT);
    localparam logic [SW-1:0]    STEP_LAST  = SW'(CNT_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOPPED
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic             lap_q, lap_d;
    logic             ovf_q, ovf_d;
    logic             running_q;

    logic [SW-1:0]    step_q, step_d;
    logic [CNT_W-1:0] sh_q, sh_d;
    logic [BW-1:0]    acc_q, acc_d, adj;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             valid_q, valid_d;

    // Command decode with priority clear > stop > start > lap; the winner alone acts.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        snap_d  = snap_q;
        lap_d   = lap_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    presc_d = '0;
                    count_d = '0;
                    snap_d  = '0;
                    lap_d   = 1'b0;
                    ovf_d   = 1'b0;
                end else if (!stop && start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop && !clear) begin
                    state_d = S_STOPPED;
                end else begin
                    if (!clear && !start && lap) begin
                        if (lap_q) begin
                            lap_d = 1'b0;
                        end else begin
                            snap_d = count_q;
                            lap_d  = 1'b1;
                        end
                    end
                    // Saturate at MAX_COUNT: hold, flag overflow and pause.
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (count_q == CNT_MAX) begin
                            ovf_d   = 1'b1;
                            state_d = S_STOPPED;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
            end
            S_STOPPED: begin
                if (clear) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    count_d = '0;
                    snap_d  = '0;
                    lap_d   = 1'b0;
                    ovf_d   = 1'b0;
                end else if (!stop && start) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Converter: one load cycle, then CNT_W add-3/shift cycles, MSB first.
    always_comb begin
        adj = acc_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        step_d  = step_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        if (step_q == '0) begin
            sh_d   = lap_q ? snap_q : count_q;
            acc_d  = '0;
            step_d = SW'(1);
        end else begin
            acc_d = BW'({adj, sh_q[CNT_W-1]});
            sh_d  = {sh_q[CNT_W-2:0], 1'b0};
            if (step_q == STEP_LAST) begin
                step_d  = '0;
                bcd_d   = acc_d;
                valid_d = 1'b1;
            end else begin
                step_d = step_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            snap_q    <= '0;
            lap_q     <= 1'b0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
            step_q    <= '0;
            sh_q      <= '0;
            acc_q     <= '0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            snap_q    <= snap_d;
            lap_q     <= lap_d;
            ovf_q     <= ovf_d;
            running_q <= (state_d == S_RUN);
            step_q    <= step_d;
            sh_q      <= sh_d;
            acc_q     <= acc_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
        end
    end

    assign bcd_out    = bcd_q;
    assign bcd_valid  = valid_q;
    assign running    = running_q;
    assign lap_active = lap_q;
    assign overflow   = ovf_q;

endmodule
